vip_gradient_edge_detector: RTL and testbench

//  Parametrised 3x3 gradient edge detector: Sobel, Prewitt or Scharr kernel selected at run time.

---
 rtl/vip_pkg.sv | 41 ++++
 rtl/vip_window_3x3_linebuf.sv | 107 ++++++++++
 rtl/vip_gradient_edge_detector.sv | 197 +++++++++++++++++++
 tb/tb_vip_gradient_edge_detector.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vip_pkg.sv
// rtl/vip_pkg.sv - shared types and constants for the gradient edge detector
//
// Purpose: kernel-mode enum, per-kernel weight table, pipeline latency and
//          width helpers used by vip_gradient_edge_detector and its window.
// Ports:   none (package)
package vip_pkg;

  typedef enum logic [1:0] {
    KM_SOBEL   = 2'd0,
    KM_PREWITT = 2'd1,
    KM_SCHARR  = 2'd2
  } kernel_mode_t;

  // Weights along the kernel axis as (outer, centre, outer).
  typedef struct packed {
    logic [3:0] outer;
    logic [3:0] centre;
  } weight_t;

  // Code 3 is not a named mode and falls back to Sobel weights.
  localparam weight_t WEIGHT_TABLE [0:3] = '{
    '{outer: 4'd1, centre: 4'd2},
    '{outer: 4'd1, centre: 4'd1},
    '{outer: 4'd3, centre: 4'd10},
    '{outer: 4'd1, centre: 4'd2}
  };

  // Clocks from input clken to post_frame_clken.
  localparam int LAT = 5;

  // |G| width: worst case is 16 * (2^DATA_W - 1).
  function automatic int g_w(input int data_w);
    return data_w + 4;
  endfunction

  // |Gx|+|Gy| width.
  function automatic int mag_w(input int data_w);
    return data_w + 5;
  endfunction

endpackage

// File: rtl/vip_window_3x3_linebuf.sv
// rtl/vip_window_3x3_linebuf.sv - two line buffers, 3x3 window and border/overflow tracking
//
// Purpose: builds a 3x3 pixel window from the incoming raster, centred on
//          pixel (row-1, col-1), and flags which window positions are fully
//          inside the frame.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   vsync/href/clken input frame sync, line valid, pixel strobe
//   pix             input grey pixel
//   win             window, win[row][col], row 0 = oldest line, col 0 = oldest pixel
//   win_valid       window registered this cycle is a real, non-border pixel
//   frame_start     vsync rising edge (combinational)
//   line_overflow   sticky: a line exceeded IMG_WIDTH in this frame
module vip_window_3x3_linebuf #(
  parameter int DATA_W    = 8,
  parameter int IMG_WIDTH = 640
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         vsync,
  input  logic                         href,
  input  logic                         clken,
  input  logic [DATA_W-1:0]            pix,
  output logic [2:0][2:0][DATA_W-1:0]  win,
  output logic                         win_valid,
  output logic                         frame_start,
  output logic                         line_overflow
);

  localparam int CNT_W  = $clog2(IMG_WIDTH + 1);
  localparam int ADDR_W = $clog2(IMG_WIDTH);
  localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(IMG_WIDTH);

  // Not reset: stale contents are only ever read behind the border mask.
  logic [DATA_W-1:0] lb_mid [IMG_WIDTH];  // previous line
  logic [DATA_W-1:0] lb_top [IMG_WIDTH];  // line before that

  logic [CNT_W-1:0]  col_cnt;
  logic [1:0]        row_cnt;
  logic              vsync_q;
  logic              href_q;
  logic              href_fall;
  logic              pix_strobe;
  logic              col_in_range;
  logic [ADDR_W-1:0] addr;

  assign frame_start  = vsync & ~vsync_q;
  assign href_fall    = href_q & ~href;
  assign pix_strobe   = clken & href;
  assign col_in_range = (col_cnt < COL_MAX);
  assign addr         = col_cnt[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (pix_strobe && col_in_range) begin
      lb_mid[addr] <= pix;
      lb_top[addr] <= lb_mid[addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      col_cnt       <= '0;
      row_cnt       <= '0;
      line_overflow <= 1'b0;
      win           <= '0;
      win_valid     <= 1'b0;
    end else begin
      vsync_q <= vsync;
      href_q  <= href;

      // Stops at IMG_WIDTH so an over-long line cannot wrap into valid columns.
      if (href_fall)
        col_cnt <= '0;
      else if (pix_strobe && col_in_range)
        col_cnt <= col_cnt + 1'b1;

      // Frame start beats a coincident line end.
      if (frame_start)
        row_cnt <= '0;
      else if (href_fall && row_cnt != 2'd2)
        row_cnt <= row_cnt + 1'b1;

      if (frame_start)
        line_overflow <= 1'b0;
      else if (pix_strobe && !col_in_range)
        line_overflow <= 1'b1;

      // Only strobed in-range pixels with two lines and two columns behind
      // them produce a real output; everything else is masked downstream.
      win_valid <= pix_strobe && col_in_range && (row_cnt == 2'd2) &&
                   (col_cnt >= CNT_W'(2));

      if (pix_strobe && col_in_range) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb_top[addr];
        win[1][2] <= lb_mid[addr];
        win[2][2] <= pix;
      end
    end
  end

endmodule

// File: rtl/vip_gradient_edge_detector.sv
// rtl/vip_gradient_edge_detector.sv - 3x3 Sobel/Prewitt/Scharr gradient edge detector
//
// Purpose: L1 gradient magnitude |Gx|+|Gy| over an internally built 3x3
//          window, thresholded to an edge bit and scaled to a pixel.
//          Five-clock pipeline: window, weighted sums, abs, magnitude, output.
// Optional: define EDGE_DIR_EN to add post_img_dir (quantised edge direction).
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   per_frame_vsync/href/clken         input sync, line valid, pixel strobe
//   per_img_Y                          input grey pixel
//   kernel_mode                        0 Sobel, 1 Prewitt, 2 Scharr, 3 Sobel
//   edge_threshold                     compared against unshifted magnitude
//   post_frame_vsync/href/clken        input controls delayed by LAT
//   post_img_Bit                       edge flag
//   post_img_mag                       min(mag >> MAG_SHIFT, 2^DATA_W-1)
//   line_overflow                      sticky per-frame line overflow
//   post_img_dir                       (EDGE_DIR_EN only) 0 horiz, 1 vert, 2/3 diagonals
module vip_gradient_edge_detector
  import vip_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int IMG_WIDTH = 640,
  parameter int MAG_SHIFT = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                per_frame_vsync,
  input  logic                per_frame_href,
  input  logic                per_frame_clken,
  input  logic [DATA_W-1:0]   per_img_Y,
  input  logic [1:0]          kernel_mode,
  input  logic [DATA_W+4:0]   edge_threshold,
  output logic                post_frame_vsync,
  output logic                post_frame_href,
  output logic                post_frame_clken,
  output logic                post_img_Bit,
  output logic [DATA_W-1:0]   post_img_mag,
  output logic                line_overflow
`ifdef EDGE_DIR_EN
  ,
  output logic [1:0]          post_img_dir
`endif
);

  localparam int G_W   = g_w(DATA_W);
  localparam int MAG_W = mag_w(DATA_W);

  logic [2:0][2:0][DATA_W-1:0] win;
  logic                        win_valid;
  logic                        frame_start;

  vip_window_3x3_linebuf #(
    .DATA_W    (DATA_W),
    .IMG_WIDTH (IMG_WIDTH)
  ) u_window (
    .clk           (clk),
    .rst_n         (rst_n),
    .vsync         (per_frame_vsync),
    .href          (per_frame_href),
    .clken         (per_frame_clken),
    .pix           (per_img_Y),
    .win           (win),
    .win_valid     (win_valid),
    .frame_start   (frame_start),
    .line_overflow (line_overflow)
  );

  // Control delay lines.
  logic [LAT-1:0] vs_d, hr_d, ck_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d <= '0;
      hr_d <= '0;
      ck_d <= '0;
    end else begin
      vs_d <= {vs_d[LAT-2:0], per_frame_vsync};
      hr_d <= {hr_d[LAT-2:0], per_frame_href};
      ck_d <= {ck_d[LAT-2:0], per_frame_clken};
    end
  end

  assign post_frame_vsync = vs_d[LAT-1];
  assign post_frame_href  = hr_d[LAT-1];
  assign post_frame_clken = ck_d[LAT-1];

  // Configuration is frozen for the whole frame at vsync rise.
  kernel_mode_t     mode_q;
  logic [MAG_W-1:0] thr_q;
  weight_t          wt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= KM_SOBEL;
      thr_q  <= '0;
    end else if (frame_start) begin
      mode_q <= kernel_mode_t'(kernel_mode);
      thr_q  <= edge_threshold;
    end
  end

  assign wt = WEIGHT_TABLE[mode_q];

  function automatic logic [G_W-1:0] wsum(input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] c,
                                          input logic [DATA_W-1:0] b,
                                          input weight_t           w);
    return G_W'(w.outer) * (G_W'(a) + G_W'(b)) + G_W'(w.centre) * G_W'(c);
  endfunction

  // Gx = right - left, Gy = bottom - top; each side is an unsigned
  // weighted sum so the difference is formed later by compare-subtract.
  logic [G_W-1:0]   sum_l, sum_r, sum_t, sum_b;
  logic [G_W-1:0]   abs_x, abs_y;
  logic [MAG_W-1:0] mag4;
  logic             v2, v3, v4;
`ifdef EDGE_DIR_EN
  logic             neg_x, neg_y;
  logic [1:0]       dir4;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_l <= '0;
      sum_r <= '0;
      sum_t <= '0;
      sum_b <= '0;
      abs_x <= '0;
      abs_y <= '0;
      mag4  <= '0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      v4    <= 1'b0;
`ifdef EDGE_DIR_EN
      neg_x <= 1'b0;
      neg_y <= 1'b0;
      dir4  <= 2'd0;
`endif
    end else begin
      // S2
      sum_l <= wsum(win[0][0], win[1][0], win[2][0], wt);
      sum_r <= wsum(win[0][2], win[1][2], win[2][2], wt);
      sum_t <= wsum(win[0][0], win[0][1], win[0][2], wt);
      sum_b <= wsum(win[2][0], win[2][1], win[2][2], wt);
      v2    <= win_valid;
      // S3
      abs_x <= (sum_r >= sum_l) ? sum_r - sum_l : sum_l - sum_r;
      abs_y <= (sum_b >= sum_t) ? sum_b - sum_t : sum_t - sum_b;
      v3    <= v2;
`ifdef EDGE_DIR_EN
      neg_x <= (sum_l > sum_r);
      neg_y <= (sum_t > sum_b);
`endif
      // S4
      mag4  <= MAG_W'(abs_x) + MAG_W'(abs_y);
      v4    <= v3;
`ifdef EDGE_DIR_EN
      if ({1'b0, abs_y} >= {abs_x, 1'b0})
        dir4 <= 2'd0;
      else if ({1'b0, abs_x} >= {abs_y, 1'b0})
        dir4 <= 2'd1;
      else if (neg_x == neg_y)
        dir4 <= 2'd2;
      else
        dir4 <= 2'd3;
`endif
    end
  end

  // S5
  logic [MAG_W-1:0]  mag_scaled;
  logic [DATA_W-1:0] mag_sat;
  logic              edge_hit;

  always_comb begin
    mag_scaled = mag4 >> MAG_SHIFT;
    mag_sat    = (mag_scaled > MAG_W'({DATA_W{1'b1}})) ? '1 : mag_scaled[DATA_W-1:0];
    edge_hit   = v4 && hr_d[LAT-2] && (mag4 >= thr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_img_Bit <= 1'b0;
      post_img_mag <= '0;
`ifdef EDGE_DIR_EN
      post_img_dir <= 2'd0;
`endif
    end else begin
      post_img_Bit <= edge_hit;
      post_img_mag <= v4 ? mag_sat : '0;
`ifdef EDGE_DIR_EN
      post_img_dir <= edge_hit ? dir4 : 2'd0;
`endif
    end
  end

endmodule

// File: tb/tb_vip_gradient_edge_detector.sv
// tb/tb_vip_gradient_edge_detector.sv - self-checking bench for vip_gradient_edge_detector
module tb_vip_gradient_edge_detector;

  localparam int DATA_W    = 8;
  localparam int IMG_W     = 16;
  localparam int MAG_SHIFT = 3;
  localparam int MAXW      = IMG_W + 3;
  localparam int MAXH      = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        per_frame_vsync = 1'b0;
  logic        per_frame_href = 1'b0;
  logic        per_frame_clken = 1'b0;
  logic [7:0]  per_img_Y = '0;
  logic [1:0]  kernel_mode = '0;
  logic [12:0] edge_threshold = '0;
  logic        post_frame_vsync, post_frame_href, post_frame_clken;
  logic        post_img_Bit;
  logic [7:0]  post_img_mag;
  logic        line_overflow;

  always #5 clk = ~clk;

  vip_gradient_edge_detector #(
    .DATA_W(DATA_W), .IMG_WIDTH(IMG_W), .MAG_SHIFT(MAG_SHIFT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
    .per_frame_clken(per_frame_clken), .per_img_Y(per_img_Y),
    .kernel_mode(kernel_mode), .edge_threshold(edge_threshold),
    .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
    .post_frame_clken(post_frame_clken), .post_img_Bit(post_img_Bit),
    .post_img_mag(post_img_mag), .line_overflow(line_overflow)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  int unsigned first_in_cyc = 0;
  int          frame_no = 0;
  logic        ovf_exp = 1'b0;
  int          pix [MAXH][MAXW];

  logic        cap_bit  [$];
  logic [7:0]  cap_mag  [$];
  logic        cap_href [$];
  int unsigned cap_cyc  [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && post_frame_clken) begin
      cap_bit.push_back(post_img_Bit);
      cap_mag.push_back(post_img_mag);
      cap_href.push_back(post_frame_href);
      cap_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: direct 3x3 convolution of the stored frame. The output for
  // input pixel (r,c) is the gradient centred on (r-1,c-1).
  function automatic void model(input int r, input int c, input int mode, input int thr,
                                output logic eb, output logic [7:0] em);
    int wo, wc, wk, gx, gy, mag, sh;
    eb = 1'b0;
    em = 8'd0;
    if (r < 2 || c < 2 || c >= IMG_W) return;
    wo = (mode == 2) ? 3 : 1;
    wc = (mode == 2) ? 10 : ((mode == 1) ? 1 : 2);
    gx = 0;
    gy = 0;
    for (int k = 0; k < 3; k++) begin
      wk = (k == 1) ? wc : wo;
      gx += wk * (pix[r-2+k][c] - pix[r-2+k][c-2]);
      gy += wk * (pix[r][c-2+k] - pix[r-2][c-2+k]);
    end
    mag = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
    eb  = (mag >= thr);
    sh  = mag >> MAG_SHIFT;
    em  = 8'((sh > 255) ? 255 : sh);
  endfunction

  task automatic fill_flat(input int v);
    for (int r = 0; r < MAXH; r++) for (int c = 0; c < MAXW; c++) pix[r][c] = v;
  endtask

  task automatic fill_step();
    for (int r = 0; r < MAXH; r++) for (int c = 0; c < MAXW; c++) pix[r][c] = (c < 4) ? 0 : 255;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < MAXH; r++) for (int c = 0; c < MAXW; c++) pix[r][c] = int'($urandom_range(0, 255));
  endtask

  task automatic frame_begin(input int mode, input int thr);
    @(negedge clk);
    check($sformatf("f%0d_ovf_before_vsync", frame_no), line_overflow, ovf_exp);
    per_frame_vsync = 1'b1;
    kernel_mode     = 2'(mode);
    edge_threshold  = 13'(thr);
    @(negedge clk);
    check($sformatf("f%0d_ovf_after_vsync", frame_no), line_overflow, 1'b0);
    ovf_exp = 1'b0;
    @(negedge clk);
    per_frame_vsync = 1'b0;
    repeat (2) @(negedge clk);
    cap_bit.delete();
    cap_mag.delete();
    cap_href.delete();
    cap_cyc.delete();
  endtask

  task automatic drive_pixel(input int r, input int c);
    @(negedge clk);
    per_frame_href  = 1'b1;
    per_frame_clken = 1'b1;
    per_img_Y       = 8'(pix[r][c]);
    if (r == 0 && c == 0) first_in_cyc = cyc;
  endtask

  task automatic drive_line(input int r, input int w);
    for (int c = 0; c < w; c++) drive_pixel(r, c);
    @(negedge clk);
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_frame(input int w, input int h, input int mode, input int thr,
                           input int chg_row, input int chg_mode, input int chg_thr);
    logic       eb;
    logic [7:0] em;
    int         i;
    frame_no++;
    frame_begin(mode, thr);
    for (int r = 0; r < h; r++) begin
      if (r == chg_row) begin
        kernel_mode    = 2'(chg_mode);
        edge_threshold = 13'(chg_thr);
      end
      drive_line(r, w);
    end
    repeat (8) @(negedge clk);
    check($sformatf("f%0d_count", frame_no), cap_bit.size(), w * h);
    if (cap_cyc.size() > 0)
      check($sformatf("f%0d_latency", frame_no), cap_cyc[0] - first_in_cyc, 5);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        i = r * w + c;
        if (i < cap_bit.size()) begin
          model(r, c, mode, thr, eb, em);
          check($sformatf("f%0d_r%0d_c%0d_bit", frame_no, r, c), cap_bit[i], eb);
          check($sformatf("f%0d_r%0d_c%0d_mag", frame_no, r, c), cap_mag[i], em);
          check($sformatf("f%0d_r%0d_c%0d_href", frame_no, r, c), cap_href[i], 1'b1);
        end
      end
    end
    ovf_exp = (w > IMG_W);
    check($sformatf("f%0d_overflow", frame_no), line_overflow, ovf_exp);
  endtask

  initial begin
    logic       eb;
    logic [7:0] em;
    int         w, h, md, th;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_vsync", post_frame_vsync, 1'b0);
    check("rst_href",  post_frame_href,  1'b0);
    check("rst_clken", post_frame_clken, 1'b0);
    check("rst_bit",   post_img_Bit,     1'b0);
    check("rst_mag",   post_img_mag,     8'd0);
    check("rst_ovf",   line_overflow,    1'b0);
    rst_n = 1'b1;

    // Flat field: no gradient anywhere
    fill_flat(100);
    run_frame(8, 8, 0, 1, -1, 0, 0);

    // Vertical step, Sobel: |G|=1020 at the two step centres
    fill_step();
    run_frame(8, 8, 0, 500, -1, 0, 0);
    check("sobel_step_c4_mag", cap_mag[4*8+4], 8'd127);
    check("sobel_step_c4_bit", cap_bit[4*8+4], 1'b1);
    check("sobel_step_c5_mag", cap_mag[4*8+5], 8'd127);
    check("sobel_step_c3_mag", cap_mag[4*8+3], 8'd0);
    check("sobel_step_c6_bit", cap_bit[4*8+6], 1'b0);

    // Scharr saturates, Prewitt does not
    run_frame(8, 8, 2, 500, -1, 0, 0);
    check("scharr_step_mag", cap_mag[3*8+4], 8'd255);
    run_frame(8, 8, 1, 500, -1, 0, 0);
    check("prewitt_step_mag", cap_mag[3*8+5], 8'd95);

    // Mid-frame config change applies only from the next frame
    fill_rand();
    run_frame(8, 8, 0, 200, 4, 2, 50);
    fill_rand();
    run_frame(8, 8, 2, 50, -1, 0, 0);

    // Over-long lines
    fill_rand();
    run_frame(IMG_W + 3, 4, 0, 100, -1, 0, 0);
    fill_rand();
    run_frame(6, 4, 1, 100, -1, 0, 0);

    // Randomised frames
    for (int k = 0; k < 4; k++) begin
      fill_rand();
      w  = int'($urandom_range(3, IMG_W));
      h  = int'($urandom_range(3, MAXH));
      md = int'($urandom_range(0, 3));
      th = int'($urandom_range(0, 800));
      run_frame(w, h, md, th, -1, 0, 0);
    end

    // Reset in the middle of a line
    fill_rand();
    frame_no++;
    frame_begin(0, 0);
    drive_line(0, 8);
    drive_line(1, 8);
    for (int c = 0; c < 8; c++) drive_pixel(2, c);
    #1;
    model(2, 2, 0, 0, eb, em);
    check("pre_reset_bit", post_img_Bit, eb);
    rst_n = 1'b0;
    #1;
    check("midreset_vsync", post_frame_vsync, 1'b0);
    check("midreset_href",  post_frame_href,  1'b0);
    check("midreset_clken", post_frame_clken, 1'b0);
    check("midreset_bit",   post_img_Bit,     1'b0);
    check("midreset_mag",   post_img_mag,     8'd0);
    check("midreset_ovf",   line_overflow,    1'b0);
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    ovf_exp = 1'b0;
    fill_rand();
    run_frame(8, 6, int'($urandom_range(0, 3)), 0, -1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
